// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI4 burst master: FSM state enums,
// burst/response encodings and a response-severity helper.
package axi_master_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AXI responses grow in severity with their encoding, so worst == max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_master_burst_check.sv
// Combinational legality check for a burst command: the start address must be
// aligned to the bus width and the burst must not run past a 4 KB boundary.
// Only the in-page offset matters, so only addr[11:0] is taken.
module axi_master_burst_check #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [11:0] addr_offset,
    input  logic [7:0]  len,
    output logic        ok
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);

    logic [13:0] span;
    logic [13:0] end_offset;
    logic        aligned;

    // Burst byte span and the offset one past its last byte; landing exactly on 4096 is legal.
    always_comb begin
        span       = ({6'd0, len} + 14'd1) << SIZE;
        end_offset = {2'b00, addr_offset} + span;
        aligned    = (addr_offset[SIZE-1:0] == '0);
        ok         = aligned && (end_offset <= 14'd4096);
    end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 burst master with independent write and read engines. Each engine
// accepts a start command when idle and legal, issues one INCR burst, and
// reports a registered done pulse (the cycle after the B handshake / the rlast
// beat) together with the burst response.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_USER_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // AW channel
    output logic [AXI_ID_WIDTH-1:0]     awid,
    output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awlock,
    output logic [3:0]                  awcache,
    output logic [2:0]                  awprot,
    output logic [3:0]                  awqos,
    output logic [3:0]                  awregion,
    output logic [AXI_USER_WIDTH-1:0]   awuser,
    output logic                        awvalid,
    input  logic                        awready,
    // W channel
    output logic [AXI_DATA_WIDTH-1:0]   wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                        wlast,
    output logic [AXI_USER_WIDTH-1:0]   wuser,
    output logic                        wvalid,
    output logic [AXI_ID_WIDTH-1:0]     wid,
    input  logic                        wready,
    // B channel
    input  logic [AXI_ID_WIDTH-1:0]     bid,
    input  logic [1:0]                  bresp,
    input  logic [AXI_USER_WIDTH-1:0]   buser,
    input  logic                        bvalid,
    output logic                        bready,
    // AR channel
    output logic [AXI_ID_WIDTH-1:0]     arid,
    output logic [AXI_ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic [3:0]                  arqos,
    output logic [3:0]                  arregion,
    output logic [AXI_USER_WIDTH-1:0]   aruser,
    output logic                        arvalid,
    input  logic                        arready,
    // R channel
    input  logic [AXI_ID_WIDTH-1:0]     rid,
    input  logic [AXI_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic [AXI_USER_WIDTH-1:0]   ruser,
    input  logic                        rvalid,
    output logic                        rready,
    // Write command / data source / status
    input  logic                        wr_start,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]                  wr_len,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    output logic                        wr_data_pop,
    output logic                        wr_busy,
    output logic                        wr_done,
    output logic [1:0]                  wr_resp,
    // Read command / data sink / status
    input  logic                        rd_start,
    input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr,
    input  logic [7:0]                  rd_len,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_data_valid,
    output logic                        rd_busy,
    output logic                        rd_done,
    output logic [1:0]                  rd_resp,
    // Command rejection
    output logic                        cmd_err
);
    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    wr_state_e                 wr_state_q, wr_state_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]                wr_len_q;
    logic [7:0]                wr_cnt_q;
    logic [1:0]                wr_resp_q;
    logic                      wr_done_q;

    rd_state_e                 rd_state_q, rd_state_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
    logic [7:0]                rd_len_q;
    logic [7:0]                rd_cnt_q;
    logic [1:0]                rd_resp_q;
    logic                      rd_done_q;

    logic                      cmd_err_q;
    logic                      wr_ok, rd_ok;
    logic                      wr_accept, wr_reject, rd_accept, rd_reject;
    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // IDs and user sidebands are fixed at zero, so the returned ones carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{bid, buser, rid, ruser};

    axi_master_burst_check #(
        .DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_wr_check (
        .addr_offset (wr_addr[11:0]),
        .len         (wr_len),
        .ok          (wr_ok)
    );

    axi_master_burst_check #(
        .DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_rd_check (
        .addr_offset (rd_addr[11:0]),
        .len         (rd_len),
        .ok          (rd_ok)
    );

    // Starts are only considered while idle; a busy engine ignores them silently.
    assign wr_accept = wr_start && (wr_state_q == W_IDLE) && wr_ok;
    assign wr_reject = wr_start && (wr_state_q == W_IDLE) && !wr_ok;
    assign rd_accept = rd_start && (rd_state_q == R_IDLE) && rd_ok;
    assign rd_reject = rd_start && (rd_state_q == R_IDLE) && !rd_ok;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // Fixed AXI attributes.
    assign awid     = '0;
    assign awsize   = AXI_SIZE;
    assign awburst  = BURST_INCR;
    assign awlock   = 1'b0;
    assign awcache  = 4'd0;
    assign awprot   = 3'd0;
    assign awqos    = 4'd0;
    assign awregion = 4'd0;
    assign awuser   = '0;
    assign wstrb    = '1;
    assign wuser    = '0;
    assign wid      = '0;
    assign arid     = '0;
    assign arsize   = AXI_SIZE;
    assign arburst  = BURST_INCR;
    assign arlock   = 1'b0;
    assign arcache  = 4'd0;
    assign arprot   = 3'd0;
    assign arqos    = 4'd0;
    assign arregion = 4'd0;
    assign aruser   = '0;

    // Write channel outputs decoded from state.
    assign awaddr      = wr_addr_q;
    assign awlen       = wr_len_q;
    assign awvalid     = (wr_state_q == W_ADDR);
    assign wvalid      = (wr_state_q == W_DATA);
    assign wdata       = wr_data;
    assign wlast       = wvalid && (wr_cnt_q == wr_len_q);
    assign wr_data_pop = w_hs;
    assign bready      = (wr_state_q == W_RESP);
    assign wr_busy     = (wr_state_q != W_IDLE);
    assign wr_done     = wr_done_q;
    assign wr_resp     = wr_resp_q;

    // Read channel outputs decoded from state.
    assign araddr        = rd_addr_q;
    assign arlen         = rd_len_q;
    assign arvalid       = (rd_state_q == R_ADDR);
    assign rready        = (rd_state_q == R_DATA);
    assign rd_data       = rdata;
    assign rd_data_valid = r_hs;
    assign rd_busy       = (rd_state_q != R_IDLE);
    assign rd_done       = rd_done_q;
    assign rd_resp       = rd_resp_q;
    assign cmd_err       = cmd_err_q;

    // Write engine next-state.
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE:  if (wr_accept)    wr_state_d = W_ADDR;
            W_ADDR:  if (aw_hs)        wr_state_d = W_DATA;
            W_DATA:  if (w_hs && wlast) wr_state_d = W_RESP;
            W_RESP:  if (b_hs)         wr_state_d = W_IDLE;
            default:                   wr_state_d = W_IDLE;
        endcase
    end

    // Read engine next-state; any rlast ends the burst, early or not.
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (rd_accept)     rd_state_d = R_ADDR;
            R_ADDR:  if (ar_hs)         rd_state_d = R_DATA;
            R_DATA:  if (r_hs && rlast) rd_state_d = R_IDLE;
            default:                    rd_state_d = R_IDLE;
        endcase
    end

    // Write engine state, command capture, beat counter and completion status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_len_q   <= 8'd0;
            wr_cnt_q   <= 8'd0;
            wr_resp_q  <= RESP_OKAY;
            wr_done_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_done_q  <= b_hs;
            if (wr_accept) begin
                wr_addr_q <= wr_addr;
                wr_len_q  <= wr_len;
                wr_cnt_q  <= 8'd0;
            end else if (w_hs) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
            if (b_hs) begin
                wr_resp_q <= bresp;
            end
        end
    end

    // Read engine state, command capture, beat counter and worst-response tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_len_q   <= 8'd0;
            rd_cnt_q   <= 8'd0;
            rd_resp_q  <= RESP_OKAY;
            rd_done_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_done_q  <= r_hs && rlast;
            if (rd_accept) begin
                rd_addr_q <= rd_addr;
                rd_len_q  <= rd_len;
                rd_cnt_q  <= 8'd0;
                rd_resp_q <= RESP_OKAY;
            end else if (r_hs) begin
                rd_cnt_q <= rd_cnt_q + 8'd1;
                if (rlast && (rd_cnt_q != rd_len_q)) begin
                    rd_resp_q <= RESP_SLVERR;
                end else begin
                    rd_resp_q <= resp_max(rd_resp_q, rresp);
                end
            end
        end
    end

    // One-cycle pulse for any rejected command on either engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= wr_reject || rd_reject;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: directed bursts plus random ones
// against a simple slave and an arithmetic model of burst legality, beat
// counts, data order and responses.
module tb_axi_burst_master;
    localparam int IDW = 1;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int UW  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0] awid, wid, bid, arid, rid;
    logic [AW-1:0]  awaddr, araddr, wr_addr, rd_addr;
    logic [7:0]     awlen, arlen, wr_len, rd_len;
    logic [2:0]     awsize, arsize, awprot, arprot;
    logic [1:0]     awburst, arburst, bresp, rresp, wr_resp, rd_resp;
    logic           awlock, arlock;
    logic [3:0]     awcache, arcache, awqos, arqos, awregion, arregion;
    logic [UW-1:0]  awuser, aruser, wuser, buser, ruser;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]  wdata, rdata, wr_data, rd_data;
    logic [DW/8-1:0] wstrb;
    logic           wr_start, wr_data_pop, wr_busy, wr_done;
    logic           rd_start, rd_data_valid, rd_busy, rd_done, cmd_err;

    int checks = 0;
    int errors = 0;

    axi_burst_master #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .AXI_USER_WIDTH (UW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .awid (awid), .awaddr (awaddr), .awlen (awlen), .awsize (awsize),
        .awburst (awburst), .awlock (awlock), .awcache (awcache), .awprot (awprot),
        .awqos (awqos), .awregion (awregion), .awuser (awuser), .awvalid (awvalid),
        .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wuser (wuser), .wvalid (wvalid),
        .wid (wid), .wready (wready),
        .bid (bid), .bresp (bresp), .buser (buser), .bvalid (bvalid), .bready (bready),
        .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
        .arburst (arburst), .arlock (arlock), .arcache (arcache), .arprot (arprot),
        .arqos (arqos), .arregion (arregion), .aruser (aruser), .arvalid (arvalid),
        .arready (arready),
        .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .ruser (ruser),
        .rvalid (rvalid), .rready (rready),
        .wr_start (wr_start), .wr_addr (wr_addr), .wr_len (wr_len), .wr_data (wr_data),
        .wr_data_pop (wr_data_pop), .wr_busy (wr_busy), .wr_done (wr_done),
        .wr_resp (wr_resp),
        .rd_start (rd_start), .rd_addr (rd_addr), .rd_len (rd_len), .rd_data (rd_data),
        .rd_data_valid (rd_data_valid), .rd_busy (rd_busy), .rd_done (rd_done),
        .rd_resp (rd_resp), .cmd_err (cmd_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave readiness: 0 always, 1 every other cycle, 2 random.
    function automatic bit pick(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Legality from plain arithmetic on byte addresses (4-byte beats).
    function automatic bit legal(input logic [31:0] addr, input int len);
        return ((addr % 4) == 0) && ((int'(addr % 4096) + (len + 1) * 4) <= 4096);
    endfunction

    task automatic idle_inputs();
        wr_start = 0; rd_start = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
    endtask

    // Rejected command: expect one cmd_err pulse and no activity.
    task automatic bad_start(input bit is_wr, input logic [31:0] addr, input logic [7:0] len);
        wr_start = is_wr;  wr_addr = addr; wr_len = len;
        rd_start = !is_wr; rd_addr = addr; rd_len = len;
        tick();
        wr_start = 0; rd_start = 0;
        chk("cmd_err pulse", cmd_err, 1);
        chk("busy after reject", {wr_busy, rd_busy}, 0);
        tick();
        chk("cmd_err single", cmd_err, 0);
        chk("valid after reject", {awvalid, arvalid, wvalid}, 0);
        chk("busy stays low", {wr_busy, rd_busy}, 0);
    endtask

    // Runs a write and/or read burst with a simple slave and checks everything seen.
    task automatic run(input bit we, input logic [31:0] wa, input logic [7:0] wl,
                       input logic [1:0] br, input bit re, input logic [31:0] ra,
                       input logic [7:0] rl, input int early, input int mode);
        logic [31:0] src [256];
        logic [31:0] rdat [256];
        logic [1:0]  rrsp [256];
        logic [1:0]  exp_rd;
        int last_beat, n_aw, n_w, n_b, n_ar, n_r, n_wd, n_rd, n_err, cyc, post;
        int b_hs_cyc, rl_hs_cyc;
        bit b_pend, r_end, b_hs, r_hs, poked_w, poked_r, fin;
        last_beat = (early >= 0) ? early : int'(rl);
        exp_rd = 2'b00;
        for (int i = 0; i < 256; i++) begin
            src[i]  = $urandom;
            rdat[i] = $urandom;
            rrsp[i] = (early >= 0) ? 2'b00 : 2'($urandom_range(0, 3));
            if (i <= last_beat && rrsp[i] > exp_rd) exp_rd = rrsp[i];
        end
        if (early >= 0) exp_rd = 2'b10;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_wd = 0; n_rd = 0; n_err = 0;
        b_hs_cyc = -10; rl_hs_cyc = -10; post = 0; fin = 0;
        b_pend = 0; r_end = 0; b_hs = 0; r_hs = 0; poked_w = 0; poked_r = 0;
        wr_start = we; wr_addr = wa; wr_len = wl;
        rd_start = re; rd_addr = ra; rd_len = rl;
        bresp = br;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                wr_start = 0; rd_start = 0;
                if (cyc == 1) begin
                    wr_addr = $urandom; wr_len = 8'($urandom);
                    rd_addr = $urandom; rd_len = 8'($urandom);
                end
                if (we && n_aw == 1 && n_b == 0 && !poked_w) begin
                    wr_start = 1; wr_addr = 32'h0; wr_len = 8'd0; poked_w = 1;
                end
                if (re && n_ar == 1 && !r_end && !poked_r) begin
                    rd_start = 1; rd_addr = 32'h3; rd_len = 8'd0; poked_r = 1;
                end
            end
            if (b_hs) bvalid = 0;
            if (r_hs) begin rvalid = 0; rlast = 0; end
            awready = pick(mode, cyc);
            arready = pick(mode, cyc);
            wready  = pick(mode, cyc);
            if (b_pend && n_b == 0 && !bvalid) bvalid = pick(mode, cyc);
            if (re && n_ar > 0 && n_r <= last_beat && !rvalid && pick(mode, cyc)) begin
                rvalid = 1; rdata = rdat[n_r]; rresp = rrsp[n_r];
                rlast = (n_r == last_beat);
            end
            wr_data = src[n_w % 256];
            #1;
            b_hs = 0; r_hs = 0;
            if (wr_done) begin
                n_wd++;
                chk("wr_done cycle", cyc, b_hs_cyc + 1);
                chk("wr_resp", wr_resp, br);
            end
            if (rd_done) begin
                n_rd++;
                chk("rd_done cycle", cyc, rl_hs_cyc + 1);
                chk("rd_resp", rd_resp, exp_rd);
            end
            if (cmd_err) n_err++;
            if (wvalid) chk("wvalid after aw", n_aw, 1);
            if (awvalid && awready) begin
                n_aw++;
                chk("awaddr", awaddr, wa);
                chk("awlen", awlen, wl);
                chk("awsize/burst", {awsize, awburst}, {3'd2, 2'b01});
            end
            if (wvalid && wready) begin
                chk("wdata", wdata, src[n_w % 256]);
                chk("wlast", wlast, n_w == int'(wl));
                chk("wstrb/pop", {wstrb, wr_data_pop}, 5'b11111);
                if (wlast) b_pend = 1;
                n_w++;
            end
            if (bvalid && bready) begin
                n_b++; b_hs_cyc = cyc; b_hs = 1;
            end
            if (arvalid && arready) begin
                n_ar++;
                chk("araddr", araddr, ra);
                chk("arlen", arlen, rl);
                chk("arsize/burst", {arsize, arburst}, {3'd2, 2'b01});
            end
            if (rvalid && rready) begin
                chk("rd_data_valid", rd_data_valid, 1);
                chk("rd_data", rd_data, rdat[n_r]);
                if (rlast) begin rl_hs_cyc = cyc; r_end = 1; end
                n_r++; r_hs = 1;
            end
            if ((!we || n_wd > 0) && (!re || n_rd > 0)) post++;
            if (post == 4) begin fin = 1; break; end
            @(posedge clk);
            #1;
        end
        chk("run completed", fin, 1);
        chk("aw count", n_aw, we ? 1 : 0);
        chk("w beats", n_w, we ? int'(wl) + 1 : 0);
        chk("wr_done count", n_wd, we ? 1 : 0);
        chk("ar count", n_ar, re ? 1 : 0);
        chk("r beats", n_r, re ? last_beat + 1 : 0);
        chk("rd_done count", n_rd, re ? 1 : 0);
        chk("no cmd_err while busy", n_err, 0);
        chk("idle after run", {wr_busy, rd_busy}, 0);
        idle_inputs();
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        int          nd;
        bid = '0; buser = '0; rid = '0; ruser = '0;
        wr_addr = 0; wr_len = 0; wr_data = 0; rd_addr = 0; rd_len = 0;
        idle_inputs();
        #12;
        chk("reset busy", {wr_busy, rd_busy}, 0);
        chk("reset valids", {awvalid, wvalid, arvalid}, 0);
        chk("reset readies", {bready, rready}, 0);
        chk("reset pulses", {wr_done, rd_done, cmd_err, rd_data_valid, wr_data_pop}, 0);
        chk("reset resp", {wr_resp, rd_resp}, 0);
        tick();
        rst_n = 1;
        tick();

        // Basic write, slave always ready.
        run(1, 32'h100, 8'd3, 2'b00, 0, 0, 0, -1, 0);
        // Read with rvalid stalled every other cycle.
        run(0, 0, 0, 2'b00, 1, 32'h200, 8'd7, -1, 1);
        // Illegal commands: 4 KB crossing and misalignment.
        bad_start(1, 32'hFF8, 8'd3);
        bad_start(0, 32'h102, 8'd0);
        bad_start(1, 32'hF04, 8'd63);
        // Burst ending exactly on the 4 KB boundary is legal.
        run(1, 32'hF00, 8'd63, 2'b00, 0, 0, 0, -1, 2);
        // Early rlast on beat 2 of len=3, and SLVERR on B.
        run(0, 0, 0, 2'b00, 1, 32'h40, 8'd3, 1, 0);
        run(1, 32'h80, 8'd1, 2'b10, 0, 0, 0, -1, 2);
        // Single-beat bursts and same-cycle starts.
        run(1, 32'h500, 8'd0, 2'b01, 1, 32'h600, 8'd0, -1, 0);
        run(1, 32'h1400, 8'd5, 2'b00, 1, 32'h2800, 8'd9, -1, 2);

        // Reset during the second write beat abandons the burst.
        awready = 1; wready = 1;
        wr_addr = 32'h300; wr_len = 8'd3; wr_start = 1;
        tick();
        wr_start = 0;
        tick();
        tick();
        chk("wvalid before reset", wvalid, 1);
        rst_n = 0;
        #1;
        chk("wvalid async reset", wvalid, 0);
        chk("busy async reset", wr_busy, 0);
        tick();
        rst_n = 1;
        awready = 0; wready = 0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr_done || wvalid || awvalid) nd++;
        end
        chk("no activity after reset", nd, 0);
        run(1, 32'h300, 8'd3, 2'b00, 0, 0, 0, -1, 0);

        // Random commands judged by the legality model.
        for (int i = 0; i < 14; i++) begin
            l = 8'($urandom_range(0, 63));
            a = $urandom & 32'hFFFF_F000;
            if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 4095));
            else a = a | 32'(4096 - $urandom_range(1, 300));
            if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
            if (legal(a, int'(l))) begin
                if ($urandom_range(0, 1) == 1)
                    run(1, a, l, 2'($urandom_range(0, 3)), 0, 0, 0, -1, 2);
                else
                    run(0, 0, 0, 2'b00, 1, a, l, -1, 2);
            end else begin
                bad_start(1'($urandom_range(0, 1)), a, l);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
